instr_fetch_unit: RTL

- Upstream neighbour of the main decoder/control block.
- Generates the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Buffers fetched instructions in a 2-entry prefetch queue and presents the queue head to decode as opcode/func fields.
- Redirects to the branch target when control asserts pc_src while the head instruction is consumed.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: registered request/address from the fetch unit,
// acknowledge plus read data returned by the memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, one-outstanding req/ack fetch, 2-entry
// prefetch queue feeding decode, and branch redirect with in-flight drop.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                stall,
  input  logic                pc_src,
  input  logic [ADDR_W-1:0]   branch_offset,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [ADDR_W-1:0]   if_pc_plus4,
  output logic [5:0]          opcode,
  output logic [5:0]          func
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] START_PC   = RESET_PC & ALIGN_MASK;

  typedef enum logic {ST_FETCH = 1'b0, ST_DROP = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;

  logic [31:0]       q_instr_q [2];
  logic [ADDR_W-1:0] q_pc4_q   [2];

  logic              ack;
  logic              consume;
  logic              redirect;
  logic              capture;
  logic              issue_ok;
  logic              pop;
  logic              launch;
  logic [ADDR_W-1:0] addr_plus4;
  logic [ADDR_W-1:0] target;

  // req_q doubles as the in-flight flag: it is set on issue and cleared on ack.
  assign ack        = imem.imem_ack & req_q;
  assign if_valid   = (count_q != 2'd0);
  assign consume    = if_valid & ~stall;
  assign redirect   = consume & pc_src;
  assign pop        = consume & ~redirect;
  assign addr_plus4 = addr_q + ADDR_W'(4);
  assign target     = (q_pc4_q[rd_ptr_q] + (branch_offset << 2)) & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      req_q      <= 1'b0;
      addr_q     <= START_PC;
      fetch_pc_q <= START_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (redirect && req_q && !ack) state_d = ST_DROP;
      ST_DROP:  if (ack) state_d = ST_FETCH;
    endcase
  end

  // An ack in DROP belongs to the pre-redirect stream and is discarded.
  always_comb begin : fsm_outputs
    capture  = 1'b0;
    issue_ok = 1'b0;
    case (state_q)
      ST_FETCH: begin
        capture  = ack & ~redirect;
        issue_ok = ~req_q;
      end
      ST_DROP: ;
    endcase
  end

  always_comb begin : queue_next
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + {1'b0, capture} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ capture;
    end
  end

  // Issue is gated on post-edge occupancy so a capture can never overflow.
  assign launch = issue_ok & (count_d < 2'd2);

  always_comb begin : fetch_next
    fetch_pc_d = fetch_pc_q;
    if (capture)  fetch_pc_d = addr_plus4;
    if (redirect) fetch_pc_d = target;

    req_d  = req_q;
    addr_d = addr_q;
    if (ack) req_d = 1'b0;
    if (launch) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      q_instr_q[wr_ptr_q] <= imem.imem_rdata;
      q_pc4_q[wr_ptr_q]   <= addr_plus4;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign if_instr    = if_valid ? q_instr_q[rd_ptr_q] : 32'd0;
  assign if_pc_plus4 = if_valid ? q_pc4_q[rd_ptr_q] : '0;
  assign opcode      = if_instr[31:26];
  assign func        = if_instr[5:0];

endmodule
